rotate_shift_pipe: RTL and testbench

Parametrised, pipelined rotate/shift unit for the SHA-256 datapath of the miner. It generalises the fixed 32-bit rotate-by-constant wiring to any power-of-two width, adds a runtime amount and four modes (ROTR, ROTL, SHR, SHL), and carries a tag. The unit is a log2(WIDTH)-stage registered barrel with a valid/ready handshake, so it can sit between message-schedule and compression-round logic under backpressure.

---
 rtl/rotate_shift_pipe.sv | 111 +++++++++++
 tb/tb_rotate_shift_pipe.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotate_shift_pipe.sv
// Pipelined rotate/shift barrel with valid/ready handshake and tag sideband.
// Modes: ROTR, ROTL, SHR and SHL with zero fill. The amount is applied one power-of-two bit per stage.
module rotate_shift_pipe #(
  parameter  int unsigned WIDTH  = 32,
  parameter  int unsigned TAG_W  = 4,
  localparam int unsigned STAGES = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [STAGES-1:0] in_amt,
  input  logic [1:0]        in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag
);

  typedef enum logic [1:0] {
    MODE_ROTR = 2'b00,
    MODE_ROTL = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_SHL  = 2'b11
  } mode_e;

  // Rank 0 captures the raw beat. Ranks 1..STAGES each apply one amount bit.
  // A result therefore appears STAGES edges after it is accepted.
  logic [STAGES:0]     vld_q, vld_d;
  logic [WIDTH-1:0]    data_q [STAGES+1];
  logic [WIDTH-1:0]    data_d [STAGES+1];
  logic [TAG_W-1:0]    tag_q  [STAGES+1];
  logic [TAG_W-1:0]    tag_d  [STAGES+1];
  mode_e               mode_q [STAGES];
  mode_e               mode_d [STAGES];
  logic [STAGES-1:0]   amt_q  [STAGES];
  logic [STAGES-1:0]   amt_d  [STAGES];
  logic                adv;

  assign out_valid = vld_q[STAGES];
  assign out_data  = data_q[STAGES];
  assign out_tag   = tag_q[STAGES];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv && !rst;

  always_comb begin
    logic [STAGES-1:0] amt_c;
    logic [WIDTH-1:0]  src_c;
    logic [WIDTH-1:0]  mv_c;
    int unsigned       sh_c;
    amt_c = '0;
    src_c = '0;
    mv_c  = '0;
    sh_c  = 0;

    vld_d[0]  = in_valid && in_ready;
    data_d[0] = in_data;
    tag_d[0]  = in_tag;
    mode_d[0] = mode_e'(in_mode);
    amt_d[0]  = in_amt;

    for (int unsigned k = 1; k < STAGES; k++) begin
      mode_d[k] = mode_q[k-1];
      amt_d[k]  = amt_q[k-1];
    end

    for (int unsigned k = 0; k < STAGES; k++) begin
      amt_c = amt_q[k];
      src_c = data_q[k];
      sh_c  = 1 << k;
      mv_c  = src_c;
      case (mode_q[k])
        MODE_ROTR: mv_c = (src_c >> sh_c) | (src_c << (WIDTH - sh_c));
        MODE_ROTL: mv_c = (src_c << sh_c) | (src_c >> (WIDTH - sh_c));
        MODE_SHR:  mv_c = src_c >> sh_c;
        MODE_SHL:  mv_c = src_c << sh_c;
        default:   mv_c = src_c;
      endcase
      data_d[k+1] = amt_c[k] ? mv_c : src_c;
      vld_d[k+1]  = vld_q[k];
      tag_d[k+1]  = tag_q[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int unsigned k = 0; k <= STAGES; k++) begin
        data_q[k] <= '0;
        tag_q[k]  <= '0;
      end
      for (int unsigned k = 0; k < STAGES; k++) begin
        mode_q[k] <= MODE_ROTR;
        amt_q[k]  <= '0;
      end
    end else if (adv) begin
      vld_q <= vld_d;
      for (int unsigned k = 0; k <= STAGES; k++) begin
        data_q[k] <= data_d[k];
        tag_q[k]  <= tag_d[k];
      end
      for (int unsigned k = 0; k < STAGES; k++) begin
        mode_q[k] <= mode_d[k];
        amt_q[k]  <= amt_d[k];
      end
    end
  end

endmodule

// File: tb/tb_rotate_shift_pipe.sv
// Directed bench for rotate_shift_pipe: a 32-bit instance plus a 64-bit instance.
module tb_rotate_shift_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_amt;
  logic [1:0]  in_mode;
  logic [3:0]  in_tag, out_tag;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [63:0] w_in_data, w_out_data;
  logic [5:0]  w_in_amt;
  logic [1:0]  w_in_mode;
  logic [3:0]  w_in_tag, w_out_tag;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  rotate_shift_pipe #(.WIDTH(32), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  rotate_shift_pipe #(.WIDTH(64), .TAG_W(4)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
    .in_amt(w_in_amt), .in_mode(w_in_mode), .in_tag(w_in_tag),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_data(w_out_data), .out_tag(w_out_tag)
  );

  function automatic logic [31:0] model(input logic [31:0] d, input int n, input logic [1:0] m);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      case (m)
        2'b00: r[i] = d[(i + n) % 32];
        2'b01: r[i] = d[(i - n + 32) % 32];
        2'b10: r[i] = (i + n < 32) ? d[(i + n) % 32] : 1'b0;
        default: r[i] = (i >= n) ? d[(i - n + 32) % 32] : 1'b0;
      endcase
    end
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 0; in_data = '0; in_amt = '0; in_mode = '0; in_tag = '0; out_ready = 1'b1;
    w_in_valid = 0; w_in_data = '0; w_in_amt = '0; w_in_mode = '0; w_in_tag = '0; w_out_ready = 1'b1;
    tick; tick;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (out_data !== 32'h0) begin miscompares++; $display("FAIL reset_out_data got %h want 0", out_data); end
    vectors++; if (out_tag !== 4'h0) begin miscompares++; $display("FAIL reset_out_tag got %h want 0", out_tag); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    vectors++; if (w_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_w_out_valid got %b want 0", w_out_valid); end
    rst = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_rotr_single(input string name);
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h12345678; in_amt = 5'd10; in_mode = 2'b00; in_tag = 4'd3;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL %s_in_ready got %b want 1", name, in_ready); end
    tick;
    in_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick;
      if (c < 5) begin
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL %s_early cycle %0d out_valid got %b want 0", name, c, out_valid); end
      end
    end
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'h9E048D15 || out_tag !== 4'd3) begin
      miscompares++;
      $display("FAIL %s_result got v=%b d=%h t=%h want v=1 d=9e048d15 t=3", name, out_valid, out_data, out_tag);
    end
    tick;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL %s_trailing got %b want 0", name, out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] din [4];
    logic [4:0]  amt [4];
    logic [1:0]  md  [4];
    logic [31:0] exp_d [4];
    din[0] = 32'h12345678; amt[0] = 5'd4;  md[0] = 2'b01; exp_d[0] = 32'h23456781;
    din[1] = 32'h80000000; amt[1] = 5'd31; md[1] = 2'b10; exp_d[1] = 32'h00000001;
    din[2] = 32'h12345678; amt[2] = 5'd8;  md[2] = 2'b11; exp_d[2] = 32'h34567800;
    din[3] = 32'hDEADBEEF; amt[3] = 5'd0;  md[3] = 2'b00; exp_d[3] = 32'hDEADBEEF;
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1; in_data = din[j]; in_amt = amt[j]; in_mode = md[j]; in_tag = 4'(j + 5);
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready beat %0d got %b want 1", j, in_ready); end
      tick;
    end
    in_valid = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      tick;
      vectors++;
      if (i >= 1 && i <= 4) begin
        if (out_valid !== 1'b1 || out_data !== exp_d[i-1] || out_tag !== 4'(i + 4)) begin
          miscompares++;
          $display("FAIL b2b_beat%0d got v=%b d=%h t=%h want v=1 d=%h t=%h", i - 1, out_valid, out_data, out_tag, exp_d[i-1], 4'(i + 4));
        end
      end else if (out_valid !== 1'b0) begin
        miscompares++; $display("FAIL b2b_gap slot %0d out_valid got %b want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp_q [$];
    logic [3:0]  expt_q [$];
    logic [31:0] prev_d, want_d;
    logic [3:0]  prev_t, want_t;
    logic        prev_stall;
    int          sent, got;
    sent = 0; got = 0; prev_stall = 1'b0; prev_d = '0; prev_t = '0;
    for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
      if (prev_stall) begin
        vectors++;
        if (out_valid !== 1'b1 || out_data !== prev_d || out_tag !== prev_t) begin
          miscompares++;
          $display("FAIL bp_stall_hold got v=%b d=%h t=%h want v=1 d=%h t=%h", out_valid, out_data, out_tag, prev_d, prev_t);
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (sent < 8) begin
        in_valid = 1'b1; in_data = $urandom; in_amt = 5'($urandom_range(0, 31));
        in_mode = 2'($urandom_range(0, 3)); in_tag = 4'(sent);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      vectors++;
      if (in_ready !== (!out_valid || out_ready)) begin
        miscompares++; $display("FAIL bp_in_ready got %b want %b", in_ready, (!out_valid || out_ready));
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data, int'(in_amt), in_mode));
        expt_q.push_back(in_tag);
        sent++;
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL bp_spurious got d=%h t=%h want none", out_data, out_tag);
        end else begin
          want_d = exp_q.pop_front();
          want_t = expt_q.pop_front();
          if (out_data !== want_d || out_tag !== want_t) begin
            miscompares++; $display("FAIL bp_result got d=%h t=%h want d=%h t=%h", out_data, out_tag, want_d, want_t);
          end
        end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data; prev_t = out_tag;
      tick;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    vectors++;
    if (got != 8 || exp_q.size() != 0) begin
      miscompares++; $display("FAIL bp_count got %0d results (%0d pending) want 8 (0)", got, exp_q.size());
    end
    for (int i = 0; i < 8; i++) tick;
  endtask

  task automatic test_bubbles;
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      in_valid = (j == 0 || j == 3);
      in_data = (j == 0) ? 32'h00000001 : 32'h0000000F;
      in_amt = (j == 0) ? 5'd1 : 5'd4;
      in_mode = (j == 0) ? 2'b00 : 2'b11;
      in_tag = (j == 0) ? 4'h5 : 4'hA;
      tick;
    end
    in_valid = 1'b0;
    tick;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bub_early got %b want 0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      tick;
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 32'h80000000 || out_tag !== 4'h5 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bub_hold_a cyc %0d got v=%b d=%h t=%h rdy=%b want v=1 d=80000000 t=5 rdy=0", i, out_valid, out_data, out_tag, in_ready);
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      vectors++;
      if (i < 2) begin
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bub_gap cyc %0d got %b want 0", i, out_valid); end
      end else if (out_valid !== 1'b1 || out_data !== 32'h000000F0 || out_tag !== 4'hA) begin
        miscompares++; $display("FAIL bub_b got v=%b d=%h t=%h want v=1 d=000000f0 t=a", out_valid, out_data, out_tag);
      end
    end
    tick;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bub_drained got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midflight;
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1; in_data = 32'hFFFF0000 | 32'(j); in_amt = '0; in_mode = 2'b00; in_tag = 4'hF;
      tick;
    end
    in_valid = 1'b0;
    tick; tick; tick;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'hFFFF0000) begin
      miscompares++; $display("FAIL rmf_fill got v=%b d=%h want v=1 d=ffff0000", out_valid, out_data);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 4'h0 || in_ready !== 1'b0) begin
      miscompares++; $display("FAIL rmf_reset got v=%b d=%h t=%h rdy=%b want all 0", out_valid, out_data, out_tag, in_ready);
    end
    tick; tick;
    rst = 1'b0;
    test_rotr_single("rmf_after");
  endtask

  task automatic test_width64;
    w_out_ready = 1'b1;
    w_in_valid = 1'b1; w_in_data = 64'h1; w_in_amt = 6'd63; w_in_mode = 2'b00; w_in_tag = 4'h9;
    #1;
    vectors++; if (w_in_ready !== 1'b1) begin miscompares++; $display("FAIL w64_in_ready got %b want 1", w_in_ready); end
    tick;
    w_in_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick;
      vectors++;
      if (c < 6) begin
        if (w_out_valid !== 1'b0) begin miscompares++; $display("FAIL w64_early cycle %0d got %b want 0", c, w_out_valid); end
      end else if (w_out_valid !== 1'b1 || w_out_data !== 64'h2 || w_out_tag !== 4'h9) begin
        miscompares++; $display("FAIL w64_result got v=%b d=%h t=%h want v=1 d=2 t=9", w_out_valid, w_out_data, w_out_tag);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_rotr_single("rotr10");
    test_back_to_back;
    test_backpressure;
    test_bubbles;
    test_reset_midflight;
    test_width64;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
